// File: rtl/aes_disp_scroller_pkg.sv
// Shared constants and helpers for the AES result display scroller.
package disp_pkg;

  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned WORD_W_DEF = 16;
  localparam int unsigned WORDS      = DATA_W_DEF / WORD_W_DEF;
  localparam int unsigned IDX_W      = $clog2(WORDS);

  function automatic int unsigned ms_to_cyc(input int unsigned hz, input int unsigned ms);
    return hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/aes_disp_scroller_if.sv
// Result-block input, button/auto controls and display-word outputs of the scroller.
interface aes_disp_scroller_if
  import disp_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned WORD_W = 16
);

  logic              blk_valid;
  logic [DATA_W-1:0] blk_data;
  logic              btn_next;
  logic              auto_en;
  logic [WORD_W-1:0] disp_word;
  logic [IDX_W-1:0]  word_idx;
  logic              blk_loaded;

  modport master (
    output blk_valid, blk_data, btn_next, auto_en,
    input  disp_word, word_idx, blk_loaded
  );

  modport slave (
    input  blk_valid, blk_data, btn_next, auto_en,
    output disp_word, word_idx, blk_loaded
  );

endinterface

// File: rtl/aes_disp_scroller_btn_debounce.sv
// Two-flop synchroniser, stable-level debouncer and rising-edge pulse for a raw push-button.
module btn_debounce #(
  parameter int unsigned DB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned DB_W = $clog2(DB_CYC + 1);

  logic [1:0]      sync_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            mismatch;
  logic            accept;

  // The level flips on the DB_CYC-th consecutive mismatching cycle; rise_o fires on that same edge.
  always_comb begin
    mismatch = sync_q[1] ^ stable_q;
    accept   = mismatch && (cnt_q == DB_W'(DB_CYC - 1));
    cnt_d    = '0;
    if (mismatch && !accept) begin
      cnt_d = cnt_q + DB_W'(1);
    end
    stable_d = accept ? sync_q[1] : stable_q;
    rise_o   = accept && sync_q[1];
    level_o  = stable_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_disp_scroller.sv
// Latches AES result blocks and steps a 16-bit display window through them by button or timer.
module aes_disp_scroller
  import disp_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned SCROLL_MS   = 1000,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned WORD_W      = 16
) (
  input logic                clk,
  input logic                rst,
  aes_disp_scroller_if.slave bus
);

  localparam int unsigned DB_CYC     = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned SCROLL_CYC = ms_to_cyc(CLK_HZ, SCROLL_MS);
  localparam int unsigned SC_W       = $clog2(SCROLL_CYC + 1);

  if (DB_CYC < 2) begin : g_bad_db
    $error("aes_disp_scroller: debounce period must be at least 2 cycles");
  end
  if (SCROLL_CYC < 2) begin : g_bad_scroll
    $error("aes_disp_scroller: scroll period must be at least 2 cycles");
  end
  if (DATA_W != WORDS * WORD_W) begin : g_bad_width
    $error("aes_disp_scroller: DATA_W must equal WORDS*WORD_W");
  end

  logic [DATA_W-1:0] blk_q, blk_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              loaded_q, loaded_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic              step_man, step_auto, run, btn_level;

  btn_debounce #(.DB_CYC(DB_CYC)) u_btn (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (bus.btn_next),
    .level_o (btn_level),
    .rise_o  (step_man)
  );

  // A load overrides any coincident step; a manual press restarts the auto period.
  always_comb begin
    run       = bus.auto_en && loaded_q;
    step_auto = run && (sc_q == SC_W'(SCROLL_CYC - 1));
    blk_d     = blk_q;
    idx_d     = idx_q;
    loaded_d  = loaded_q;
    sc_d      = sc_q + SC_W'(1);
    if (!run || step_man || step_auto) begin
      sc_d = '0;
    end
    if ((step_man || step_auto) && loaded_q) begin
      idx_d = idx_q + IDX_W'(1);
    end
    if (bus.blk_valid) begin
      blk_d    = bus.blk_data;
      idx_d    = '0;
      sc_d     = '0;
      loaded_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q    <= '0;
      idx_q    <= '0;
      loaded_q <= 1'b0;
      sc_q     <= '0;
    end else begin
      blk_q    <= blk_d;
      idx_q    <= idx_d;
      loaded_q <= loaded_d;
      sc_q     <= sc_d;
    end
  end

  always_comb begin
    bus.disp_word  = blk_q[DATA_W-1-WORD_W*int'(idx_q) -: WORD_W];
    bus.word_idx   = idx_q;
    bus.blk_loaded = loaded_q;
  end

endmodule

// File: tb/tb_aes_disp_scroller.sv
// Randomised and directed check of aes_disp_scroller against a cycle-level behavioural model.
module tb_aes_disp_scroller;
  import disp_pkg::*;

  localparam int DB = 4;
  localparam int SC = 10;
  localparam logic [127:0] K1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_disp_scroller_if #(.DATA_W(128), .WORD_W(16)) bus ();

  aes_disp_scroller #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .SCROLL_MS(10), .DATA_W(128), .WORD_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  logic [127:0] m_blk;
  int m_idx, m_run, cyc, m_restart;
  bit m_loaded, m_s1, m_s2, m_stable;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_word();
    logic [127:0] sh;
    sh = m_blk >> (16 * (7 - m_idx));
    return sh[15:0];
  endfunction

  function automatic void model_edge();
    bit man, running, fire;
    cyc++;
    if (rst) begin
      m_blk = '0; m_idx = 0; m_loaded = 0;
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_run = 0;
      m_restart = cyc;
      return;
    end
    man = 0;
    if (m_s2 != m_stable) begin
      m_run++;
      if (m_run == DB) begin
        m_stable = m_s2;
        m_run = 0;
        man = m_s2;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = bus.btn_next;
    running = bus.auto_en && m_loaded;
    fire = running && (cyc - m_restart == SC);
    if (bus.blk_valid) begin
      m_blk = bus.blk_data; m_idx = 0; m_loaded = 1; m_restart = cyc;
    end else begin
      if ((man || fire) && m_loaded) m_idx = (m_idx + 1) % 8;
      if (!running || man || fire) m_restart = cyc;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("disp_word", bus.disp_word, m_word());
    check("word_idx", bus.word_idx, m_idx);
    check("blk_loaded", bus.blk_loaded, m_loaded);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic press();
    bus.btn_next = 1'b1; run(8);
    bus.btn_next = 1'b0; run(8);
  endtask

  logic [15:0] w [8] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF,
                         16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};

  initial begin
    logic [127:0] k2;
    int prev, k;
    bit seen;
    rst = 1'b1;
    bus.blk_valid = 1'b0; bus.blk_data = '0; bus.btn_next = 1'b0; bus.auto_en = 1'b0;
    run(3);
    check("rst_disp", bus.disp_word, 0);
    check("rst_idx", bus.word_idx, 0);
    check("rst_loaded", bus.blk_loaded, 0);
    rst = 1'b0;
    run(2);

    // Steps before any block is loaded are ignored
    press(); press();
    check("preload_idx", bus.word_idx, 0);
    check("preload_disp", bus.disp_word, 0);

    bus.blk_data = K1; bus.blk_valid = 1'b1; cycle(); bus.blk_valid = 1'b0;
    check("load_disp", bus.disp_word, 16'h0123);
    check("load_idx", bus.word_idx, 0);
    check("load_flag", bus.blk_loaded, 1);

    for (int i = 1; i <= 8; i++) begin
      press();
      check("press_idx", bus.word_idx, i % 8);
      check("press_disp", bus.disp_word, w[i % 8]);
    end

    bus.btn_next = 1'b1; run(3); bus.btn_next = 1'b0; run(8);
    check("glitch_idx", bus.word_idx, 0);

    begin
      bit pat [6] = '{1, 0, 1, 1, 1, 1};
      for (int i = 0; i < 6; i++) begin bus.btn_next = pat[i]; cycle(); end
      run(4); bus.btn_next = 1'b0; run(8);
      check("bounce_idx", bus.word_idx, 1);
    end

    // Auto-scroll period, then a manual press restarting it
    bus.auto_en = 1'b1;
    prev = bus.word_idx; k = 0;
    while (bus.word_idx == prev[2:0] && k < 20) begin cycle(); k++; end
    check("auto_first", bus.word_idx, (prev + 1) % 8);
    prev = bus.word_idx;
    run(9); check("auto_hold", bus.word_idx, prev);
    run(1); check("auto_period", bus.word_idx, (prev + 1) % 8);
    prev = bus.word_idx;
    bus.btn_next = 1'b1; k = 0;
    while (bus.word_idx == prev[2:0] && k < 12) begin cycle(); k++; end
    check("mid_press", bus.word_idx, (prev + 1) % 8);
    bus.btn_next = 1'b0;
    prev = bus.word_idx;
    run(9); check("restart_hold", bus.word_idx, prev);
    run(1); check("restart_step", bus.word_idx, (prev + 1) % 8);

    // Load coinciding with an auto step at word 5
    k = 0; seen = 0;
    while (!seen && k < 100) begin
      prev = bus.word_idx; cycle(); k++;
      seen = (bus.word_idx == 3'd5) && (prev != 5);
    end
    check("reach_idx5", {31'd0, seen}, 1);
    run(9);
    k2 = {$urandom, $urandom, $urandom, $urandom};
    bus.blk_data = k2; bus.blk_valid = 1'b1; cycle(); bus.blk_valid = 1'b0;
    check("coinc_idx", bus.word_idx, 0);
    check("coinc_disp", bus.disp_word, k2[127:112]);
    run(9); check("coinc_hold", bus.word_idx, 0);
    run(1); check("coinc_next", bus.word_idx, 1);

    // Reset mid-operation with the button held
    bus.auto_en = 1'b0; k = 0;
    while (bus.word_idx != 3'd3 && k < 8) begin press(); k++; end
    check("pre_rst_idx", bus.word_idx, 3);
    bus.btn_next = 1'b1; run(3);
    rst = 1'b1; run(2);
    check("mid_rst_disp", bus.disp_word, 0);
    check("mid_rst_idx", bus.word_idx, 0);
    check("mid_rst_loaded", bus.blk_loaded, 0);
    rst = 1'b0;
    bus.blk_data = K1; bus.blk_valid = 1'b1; cycle(); bus.blk_valid = 1'b0;
    run(3); check("redebounce_hold", bus.word_idx, 0);
    k = 0;
    while (bus.word_idx == 3'd0 && k < 6) begin cycle(); k++; end
    check("redebounce_step", bus.word_idx, 1);
    bus.btn_next = 1'b0; run(8);

    // Random traffic
    repeat (400) begin
      int n;
      bus.btn_next = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 10);
      for (int j = 0; j < n; j++) begin
        bus.blk_valid = ($urandom_range(0, 39) == 0);
        if (bus.blk_valid) bus.blk_data = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 99) == 0) bus.auto_en = ~bus.auto_en;
        rst = ($urandom_range(0, 299) == 0);
        cycle();
      end
    end
    rst = 1'b0; bus.blk_valid = 1'b0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
